// File: rtl/mul_issue_ctrl_if.sv
// Signal bundle between the EX stage, mul_issue_ctrl and the iterative multiplier.
// slave is the controller's view; master is the view of whoever drives it.
interface mul_issue_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic              ex_valid;
  logic [1:0]        ex_op;
  logic [XLEN-1:0]   ex_rs1;
  logic [XLEN-1:0]   ex_rs2;
  logic              ex_flush;
  logic              ex_stall;
  logic              ex_done;
  logic [XLEN-1:0]   ex_result;
  logic              mul_in_valid;
  logic [XLEN-1:0]   mul_mplier;
  logic [XLEN-1:0]   mul_mcand;
  logic [2*XLEN-1:0] mul_product;
  logic              mul_out_valid;
  logic              mul_stall;

  modport slave (
    input  ex_valid, ex_op, ex_rs1, ex_rs2, ex_flush, mul_product, mul_out_valid, mul_stall,
    output ex_stall, ex_done, ex_result, mul_in_valid, mul_mplier, mul_mcand
  );

  modport master (
    output ex_valid, ex_op, ex_rs1, ex_rs2, ex_flush, mul_product, mul_out_valid, mul_stall,
    input  ex_stall, ex_done, ex_result, mul_in_valid, mul_mplier, mul_mcand
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// EX-stage control for MUL/MULH/MULHSU/MULHU around an unsigned iterative multiplier.
// Converts signed operands to magnitudes, issues, waits, sign-corrects the product and
// keeps a one-entry result cache so MULH followed by MUL on the same operands skips the issue.
module mul_issue_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter bit          CACHE_EN = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  mul_issue_ctrl_if.slave bus
);
  localparam int unsigned PW = 2 * XLEN;

  // Signedness class; MUL and MULHU share the unsigned class.
  localparam logic [1:0] ModeUu = 2'd0;
  localparam logic [1:0] ModeSs = 2'd1;
  localparam logic [1:0] ModeSu = 2'd2;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mplier_q, mcand_q, rs1_q, rs2_q;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [PW-1:0]     prod_q;
  logic              cache_valid_q;
  logic [XLEN-1:0]   cache_rs1_q, cache_rs2_q;
  logic [1:0]        cache_mode_q;
  logic [PW-1:0]     cache_prod_q;

  logic              rs1_signed, rs2_signed, neg_in, cache_hit;
  logic [1:0]        mode_in;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic [PW-1:0]     corr_prod;
  logic              accept, capture, cache_wr;

  function automatic logic [1:0] mode_of(input logic [1:0] op);
    unique case (op)
      2'b01:   mode_of = ModeSs;
      2'b10:   mode_of = ModeSu;
      default: mode_of = ModeUu;
    endcase
  endfunction

  // Low half for MUL, high half for every other op.
  function automatic logic [XLEN-1:0] res_sel(input logic [1:0] op, input logic [PW-1:0] p);
    res_sel = (op == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // Operand decode, magnitude conversion, cache lookup and product sign correction.
  always_comb begin
    rs1_signed = (bus.ex_op == 2'b01) || (bus.ex_op == 2'b10);
    rs2_signed = (bus.ex_op == 2'b01);
    rs1_mag    = (rs1_signed && bus.ex_rs1[XLEN-1]) ? (~bus.ex_rs1 + XLEN'(1)) : bus.ex_rs1;
    rs2_mag    = (rs2_signed && bus.ex_rs2[XLEN-1]) ? (~bus.ex_rs2 + XLEN'(1)) : bus.ex_rs2;
    neg_in     = (rs1_signed && bus.ex_rs1[XLEN-1]) ^ (rs2_signed && bus.ex_rs2[XLEN-1]);
    mode_in    = mode_of(bus.ex_op);
    // The low half is sign-independent, so MUL hits against any stored mode.
    cache_hit  = CACHE_EN && cache_valid_q && (bus.ex_rs1 == cache_rs1_q) &&
                 (bus.ex_rs2 == cache_rs2_q) && ((bus.ex_op == 2'b00) || (mode_in == cache_mode_q));
    corr_prod  = neg_q ? (~bus.mul_product + PW'(1)) : bus.mul_product;
  end

  // Next-state and handshake outputs; flush always wins over hit/accept.
  always_comb begin
    state_d          = state_q;
    bus.ex_stall     = 1'b0;
    bus.ex_done      = 1'b0;
    bus.ex_result    = '0;
    bus.mul_in_valid = 1'b0;
    accept           = 1'b0;
    capture          = 1'b0;
    cache_wr         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.ex_valid && !bus.ex_flush) begin
          if (cache_hit) begin
            bus.ex_done   = 1'b1;
            bus.ex_result = res_sel(bus.ex_op, cache_prod_q);
          end else begin
            accept       = 1'b1;
            bus.ex_stall = 1'b1;
            state_d      = StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.ex_flush) begin
          state_d = StIdle;
        end else begin
          bus.mul_in_valid = 1'b1;
          bus.ex_stall     = 1'b1;
          if (!bus.mul_stall) state_d = StWait;
        end
      end
      StWait: begin
        if (bus.ex_flush) begin
          // A product landing in the flush cycle is already the one to discard.
          state_d = bus.mul_out_valid ? StIdle : StDrain;
        end else begin
          bus.ex_stall = 1'b1;
          if (bus.mul_out_valid) begin
            capture = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!bus.ex_flush) begin
          bus.ex_done   = 1'b1;
          bus.ex_result = res_sel(op_q, prod_q);
          cache_wr      = 1'b1;
        end
        state_d = StIdle;
      end
      StDrain: begin
        bus.ex_stall = bus.ex_valid;
        if (bus.mul_out_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.mul_mplier = mplier_q;
  assign bus.mul_mcand  = mcand_q;

  // State, operand capture, product capture and cache entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mplier_q      <= '0;
      mcand_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      prod_q        <= '0;
      cache_valid_q <= 1'b0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_mode_q  <= ModeUu;
      cache_prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mplier_q <= rs1_mag;
        mcand_q  <= rs2_mag;
        rs1_q    <= bus.ex_rs1;
        rs2_q    <= bus.ex_rs2;
        op_q     <= bus.ex_op;
        neg_q    <= neg_in;
      end
      if (capture) prod_q <= corr_prod;
      if (cache_wr) begin
        cache_valid_q <= 1'b1;
        cache_rs1_q   <= rs1_q;
        cache_rs2_q   <= rs2_q;
        cache_mode_q  <= mode_of(op_q);
        cache_prod_q  <= prod_q;
      end
    end
  end
endmodule
